// File: rtl/mt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mt_pkg
// Description : Shared MT19937 constants and types for the seed loader and
//               the mersenne_twister core.
// Revision    : 1.0  initial release
// ============================================================================
package mt_pkg;

    localparam int unsigned W     = 32;
    localparam int unsigned N     = 624;
    localparam int unsigned SHIFT = 30;
    localparam int unsigned IDX_W = $clog2(N);

    typedef logic [W-1:0]     word_t;
    typedef logic [IDX_W-1:0] idx_t;

    localparam word_t F        = 32'h6C07_8965;
    localparam idx_t  LAST_IDX = idx_t'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : mt_pkg
`default_nettype wire

// File: rtl/mt_seed_step.sv
`default_nettype none
// ============================================================================
// Module      : mt_seed_step
// Description : One step of the init_genrand recurrence:
//               next = (F * (prev ^ (prev >> SHIFT)) + idx) mod 2^W
// Revision    : 1.0  initial release
// ============================================================================
module mt_seed_step
    import mt_pkg::*;
(
    input  word_t prev_i,
    input  idx_t  idx_i,
    output word_t next_o
);

    word_t w_mix;

    // Product lands in a W-bit context so it truncates before the index add.
    assign w_mix  = prev_i ^ (prev_i >> SHIFT);
    assign next_o = (F * w_mix) + word_t'(idx_i);

endmodule : mt_seed_step
`default_nettype wire

// File: rtl/mt_seed_loader.sv
`default_nettype none
// ============================================================================
// Module      : mt_seed_loader
// Description : Expands a 32-bit seed into the N MT19937 state words and
//               streams them in index order on the load_value/value port.
// Revision    : 1.0  initial release
// ============================================================================
module mt_seed_loader
    import mt_pkg::*;
(
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [W-1:0] seed,
    input  logic         hold,
    output logic         load_value,
    output logic [W-1:0] value,
    output logic         busy,
    output logic         done
);

    state_t state_q, state_d;
    word_t  seed_q,  seed_d;
    logic   pend_q,  pend_d;
    logic   load_q,  load_d;
    word_t  value_q, value_d;
    logic   busy_q,  busy_d;
    logic   done_q,  done_d;
    idx_t   index_q, index_d;

    idx_t   index_inc;
    word_t  next_word;

    assign index_inc = idx_t'(index_q + idx_t'(1));

    // Next word is derived from the word currently on the output.
    mt_seed_step u_step (
        .prev_i (value_q),
        .idx_i  (index_inc),
        .next_o (next_word)
    );

    // Next-state and output decode; pend_q marks a captured seed awaiting
    // its first emission on the following edge.
    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        pend_d  = pend_q;
        load_d  = 1'b0;
        value_d = value_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        index_d = index_q;
        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    value_d = seed_q;
                    load_d  = 1'b1;
                    busy_d  = 1'b1;
                    index_d = '0;
                    pend_d  = 1'b0;
                    state_d = ST_EMIT;
                end else if (start) begin
                    seed_d = seed;
                    pend_d = 1'b1;
                end
            end
            ST_EMIT: begin
                if (!hold) begin
                    if (index_q == LAST_IDX) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        value_d = next_word;
                        index_d = index_inc;
                        load_d  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            seed_q  <= '0;
            pend_q  <= 1'b0;
            load_q  <= 1'b0;
            value_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            pend_q  <= pend_d;
            load_q  <= load_d;
            value_q <= value_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            index_q <= index_d;
        end
    end

    assign load_value = load_q;
    assign value      = value_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule : mt_seed_loader
`default_nettype wire

// File: tb/tb_mt_seed_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mt_seed_loader
// Description : Scoreboard bench for mt_seed_loader with a reference model
//               of the init_genrand expansion.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mt_seed_loader;

    localparam int NW = 624;

    logic        clk;
    logic        n_rst;
    logic        start;
    logic [31:0] seed;
    logic        hold;
    logic        load_value;
    logic [31:0] value;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got[$];
    logic [31:0] ref_5489[$];

    mt_seed_loader dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .seed       (seed),
        .hold       (hold),
        .load_value (load_value),
        .value      (value),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic, keep the low 32 bits.
    function automatic logic [31:0] model_next(input logic [31:0] prev, input int i);
        logic [63:0] p;
        p = 64'(prev ^ (prev >> 30)) * 64'd1812433253;
        return p[31:0] + 32'(i);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Monitor: every emitted word is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (load_value === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: actual=0x%08h required=<none>", value);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (value !== e) begin
                    errors++;
                    $display("FAIL word: actual=0x%08h required=0x%08h", value, e);
                end
            end
        end
    end

    task automatic run_seq(input logic [31:0] s, input int hold_after, input int hold_len,
                           input int restart_at, input int abort_at);
        logic [31:0] w;
        int          nwords;
        int          seen;
        int          hold_left;
        bit          done_seen;
        bit          start_clr;
        w = s;
        nwords = (abort_at >= 0) ? abort_at + 1 : NW;
        exp_q.delete();
        got.delete();
        for (int i = 0; i < nwords; i++) begin
            exp_q.push_back(w);
            w = model_next(w, i + 1);
        end
        seen = 0;
        hold_left = -1;
        done_seen = 1'b0;
        start_clr = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        seed  = s;
        @(posedge clk); #1;
        start = 1'b0;
        seed  = $urandom;
        for (int k = 1; k <= NW + hold_len + 20 && !done_seen; k++) begin
            @(posedge clk); #1;
            if (start_clr) begin
                start = 1'b0;
                start_clr = 1'b0;
            end
            if (hold_left > 0) begin
                chk("hold_load", {31'd0, load_value}, 32'd0);
                hold_left--;
                if (hold_left == 0) hold = 1'b0;
            end
            if (load_value) begin
                got.push_back(value);
                seen++;
                if (seen == 1) chk("busy_first", {31'd0, busy}, 32'd1);
                if (hold_len > 0 && hold_left < 0 && seen - 1 == hold_after) begin
                    hold = 1'b1;
                    hold_left = hold_len;
                end
                if (seen - 1 == restart_at) begin
                    start = 1'b1;
                    seed  = 32'h1234_5678;
                    start_clr = 1'b1;
                end
                if (seen - 1 == abort_at) begin
                    n_rst = 1'b0;
                    @(posedge clk); #1;
                    n_rst = 1'b1;
                    chk("abort_load", {31'd0, load_value}, 32'd0);
                    chk("abort_value", value, 32'd0);
                    chk("abort_busy", {31'd0, busy}, 32'd0);
                    chk("abort_done", {31'd0, done}, 32'd0);
                    for (int j = 0; j < 5; j++) begin
                        @(posedge clk); #1;
                        chk("abort_no_done", {31'd0, done | load_value}, 32'd0);
                    end
                    chk("abort_count", 32'(exp_q.size()), 32'd0);
                    return;
                end
            end
            if (done) begin
                done_seen = 1'b1;
                chk("done_latency", 32'(k), 32'(NW + 1 + hold_len));
                chk("done_busy", {31'd0, busy}, 32'd0);
                chk("done_load", {31'd0, load_value}, 32'd0);
            end
        end
        if (!done_seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: actual=no done required=done pulse");
        end
        chk("word_count", 32'(seen), 32'(NW));
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        chk("done_pulse", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        chk("value_kept", value, exp_q.size() == 0 && got.size() > 0 ? got[got.size()-1] : 32'hFFFF_FFFF);
    endtask

    initial begin
        int mism;
        n_rst = 1'b0;
        start = 1'b0;
        seed  = '0;
        hold  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_load", {31'd0, load_value}, 32'd0);
        chk("rst_value", value, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        n_rst = 1'b1;

        // Canonical seed, no hold.
        run_seq(32'd5489, -1, 0, -1, -1);
        chk("s5489_w0", got[0], 32'h0000_1571);
        chk("s5489_w1", got[1], 32'h4D98_EE96);
        ref_5489 = got;

        // Seed zero.
        run_seq(32'd0, -1, 0, -1, -1);
        chk("s0_w0", got[0], 32'h0000_0000);
        chk("s0_w1", got[1], 32'h0000_0001);
        chk("s0_w2", got[2], 32'h6C07_8967);

        // Hold for 3 cycles after word 10.
        run_seq(32'd5489, 10, 3, -1, -1);
        mism = 0;
        for (int i = 0; i < NW; i++) if (got[i] !== ref_5489[i]) mism++;
        chk("hold_same_seq", 32'(mism), 32'd0);

        // Start pulse during emission is ignored.
        run_seq(32'd5489, -1, 0, 100, -1);
        mism = 0;
        for (int i = 0; i < NW; i++) if (got[i] !== ref_5489[i]) mism++;
        chk("restart_ignored", 32'(mism), 32'd0);

        // Reset at word 300, then a fresh seed.
        run_seq(32'd5489, -1, 0, -1, 300);
        run_seq(32'd1, -1, 0, -1, -1);
        chk("s1_w0", got[0], 32'h0000_0001);
        chk("s1_w1", got[1], 32'h6C07_8966);

        // Start coinciding with reset: reset wins.
        @(posedge clk); #1;
        n_rst = 1'b0;
        start = 1'b1;
        seed  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        n_rst = 1'b1;
        start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            chk("rst_start_idle", {30'd0, load_value, busy}, 32'd0);
        end

        // Random seeds with random hold placement.
        for (int r = 0; r < 3; r++) begin
            run_seq($urandom, int'($urandom_range(0, NW - 2)), int'($urandom_range(1, 6)), -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mt_seed_loader
`default_nettype wire
